// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver
//   rx_state_e : receiver FSM states
//   rx_cfg_t   : per-frame configuration captured at the start edge
//   rx_entry_t : one FIFO entry, parity status plus LSB-aligned character
//   MIN_DIV    : smallest usable clocks-per-bit divisor
package uart_rx_pkg;

    localparam int MIN_DIV   = 4;
    // Divisor field is sized for the widest supported DIV_W (up to 32).
    localparam int CFG_DIV_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    typedef struct packed {
        logic [CFG_DIV_W-1:0] div;
        logic [1:0]           bits;
        logic                 parity_en;
        logic                 parity_odd;
        logic                 stop2;
    } rx_cfg_t;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO of received characters
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write entry_i (ignored when full unless a pop happens too)
//   entry_i      : entry to write
//   pop_i        : consumer pop request (ignored when empty, no bypass)
//   entry_o      : head entry, all zeros when empty
//   valid_o      : FIFO non-empty
//   accept_o     : push_i was accepted this cycle
//   drop_o       : push_i was dropped because the FIFO was full
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  rx_entry_t entry_i,
    input  logic      pop_i,
    output rx_entry_t entry_o,
    output logic      valid_o,
    output logic      accept_o,
    output logic      drop_o
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t     r_mem [DEPTH];
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty  = (r_wr == r_rd);
    assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop    = pop_i && !w_empty;
    assign accept_o = push_i && (!w_full || w_pop);
    assign drop_o   = push_i && w_full && !w_pop;
    assign valid_o  = !w_empty;
    assign entry_o  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (accept_o)
                r_wr <= r_wr + (AW+1)'(1);
            if (w_pop)
                r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept_o)
            r_mem[r_wr[AW-1:0]] <= entry_i;
    end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: configurable UART receiver with character FIFO
//   clk_i, rst_i       : clock, synchronous active-high reset
//   rx_en_i, rx_i      : receiver enable, serial line (idles high)
//   cfg_*              : divisor (min 4), data bits-5, parity enable/odd, two stop bits
//   data_o, perr_o     : FIFO head character and its parity error flag
//   valid_o, ready_i   : output stream handshake
//   frame_err_o        : sticky, a stop bit was sampled low
//   overrun_o          : sticky, a character was dropped on a full FIFO
//   err_clr_i          : clears both sticky flags (a coincident set wins)
//   newline_o          : one-cycle pulse when 8'h0A is accepted into the FIFO
//   busy_o             : receiver is not idle
// DIV_W must not exceed 32.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_en_i,
    input  logic             rx_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [1:0]       cfg_bits_i,
    input  logic             cfg_parity_en_i,
    input  logic             cfg_parity_odd_i,
    input  logic             cfg_stop2_i,
    output logic [7:0]       data_o,
    output logic             perr_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_err_o,
    output logic             overrun_o,
    input  logic             err_clr_i,
    output logic             newline_o,
    output logic             busy_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    rx_state_e              r_state;
    rx_cfg_t                r_cfg;
    logic [CFG_DIV_W-1:0]   r_cnt;
    logic [2:0]             r_bit;
    logic                   r_stop;
    logic [7:0]             r_data;
    logic                   r_perr;
    logic                   r_push;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic                   w_rx_s;
    logic [DIV_W-1:0]       w_div_in;
    logic                   w_timed;
    logic                   w_tick;
    logic                   w_ferr_set;
    logic                   w_accept;
    logic                   w_drop;
    rx_entry_t              w_head;

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_div_in   = (cfg_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div_i;
    assign w_timed    = r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    // Counter expires on its last count; every sample reloads it.
    assign w_tick     = (r_cnt <= CFG_DIV_W'(1));
    assign w_ferr_set = (r_state == ST_STOP) && w_tick && !w_rx_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync      <= '1;
            r_rx_prev   <= 1'b1;
            r_state     <= ST_IDLE;
            r_cfg       <= '0;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_stop      <= 1'b0;
            r_data      <= '0;
            r_perr      <= 1'b0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_rx_prev   <= w_rx_s;
            r_push      <= 1'b0;
            r_frame_err <= w_ferr_set | (r_frame_err & ~err_clr_i);
            r_overrun   <= w_drop | (r_overrun & ~err_clr_i);
            if (w_timed && !w_tick)
                r_cnt <= r_cnt - CFG_DIV_W'(1);
            case (r_state)
                ST_IDLE: begin
                    if (rx_en_i && r_rx_prev && !w_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= CFG_DIV_W'(w_div_in >> 1);
                        r_cfg   <= '{div: CFG_DIV_W'(w_div_in), bits: cfg_bits_i,
                                     parity_en: cfg_parity_en_i,
                                     parity_odd: cfg_parity_odd_i, stop2: cfg_stop2_i};
                        r_data  <= '0;
                        r_perr  <= 1'b0;
                        r_bit   <= '0;
                        r_stop  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_cnt   <= r_cfg.div;
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_data[r_bit] <= w_rx_s;
                        r_bit         <= r_bit + 3'd1;
                        r_cnt         <= r_cfg.div;
                        // Last data bit index is bits+4, i.e. {1, bits}.
                        if (r_bit == {1'b1, r_cfg.bits})
                            r_state <= r_cfg.parity_en ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_perr  <= (^r_data) ^ w_rx_s ^ r_cfg.parity_odd;
                        r_cnt   <= r_cfg.div;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (!w_rx_s) begin
                            r_state <= ST_WAIT_IDLE;
                        end else if (r_cfg.stop2 && !r_stop) begin
                            r_stop <= 1'b1;
                            r_cnt  <= r_cfg.div;
                        end else begin
                            r_push  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_rx_s)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (r_push),
        .entry_i ({r_perr, r_data}),
        .pop_i   (ready_i),
        .entry_o (w_head),
        .valid_o (valid_o),
        .accept_o(w_accept),
        .drop_o  (w_drop)
    );

    assign data_o      = w_head.data;
    assign perr_o      = w_head.perr;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
    assign newline_o   = w_accept && (r_data == 8'h0A);
    assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core with a serial-frame reference model
module tb_uart_rx_core;

    localparam int FIFO_DEPTH  = 4;
    localparam int DIV_W       = 16;
    localparam int SYNC_STAGES = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             rx_en_i;
    logic             rx_i;
    logic [DIV_W-1:0] cfg_div_i;
    logic [1:0]       cfg_bits_i;
    logic             cfg_parity_en_i;
    logic             cfg_parity_odd_i;
    logic             cfg_stop2_i;
    logic [7:0]       data_o;
    logic             perr_o;
    logic             valid_o;
    logic             ready_i;
    logic             frame_err_o;
    logic             overrun_o;
    logic             err_clr_i;
    logic             newline_o;
    logic             busy_o;

    int         errors = 0;
    int         checks = 0;
    int         nl_cnt = 0;
    logic [8:0] q[$];

    always #5 clk_i = ~clk_i;

    uart_rx_core #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .rx_en_i         (rx_en_i),
        .rx_i            (rx_i),
        .cfg_div_i       (cfg_div_i),
        .cfg_bits_i      (cfg_bits_i),
        .cfg_parity_en_i (cfg_parity_en_i),
        .cfg_parity_odd_i(cfg_parity_odd_i),
        .cfg_stop2_i     (cfg_stop2_i),
        .data_o          (data_o),
        .perr_o          (perr_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .frame_err_o     (frame_err_o),
        .overrun_o       (overrun_o),
        .err_clr_i       (err_clr_i),
        .newline_o       (newline_o),
        .busy_o          (busy_o)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int eff_div(input int dv);
        return (dv < 4) ? 4 : dv;
    endfunction

    function automatic int exp_lat(input int d, input int nb, input int pe, input int ns);
        return SYNC_STAGES + 1 + d / 2 + d * (nb + pe + ns) + 1;
    endfunction

    function automatic logic [7:0] mask_of(input int nb);
        return 8'((32'd1 << nb) - 1);
    endfunction

    // Even parity wants an even total count of ones, odd parity an odd one.
    function automatic bit exp_perr(input logic [7:0] d, input int nb, input bit pe, input bit od, input bit pb);
        int ones;
        if (!pe) return 1'b0;
        ones = $countones(d & mask_of(nb)) + int'(pb);
        return (ones % 2) != int'(od);
    endfunction

    function automatic bit good_pbit(input logic [7:0] d, input int nb, input bit od);
        return ((^(d & mask_of(nb))) ^ od);
    endfunction

    task automatic set_cfg(input int dv, input int nb, input bit pe, input bit od, input bit s2);
        cfg_div_i        = DIV_W'(dv);
        cfg_bits_i       = 2'(nb - 5);
        cfg_parity_en_i  = pe;
        cfg_parity_odd_i = od;
        cfg_stop2_i      = s2;
    endtask

    // Model of the FIFO occupancy: a full FIFO drops unless a pop lands on the push cycle.
    task automatic expect_char(input logic [7:0] d, input bit perr, input bit pop_planned);
        if (q.size() >= FIFO_DEPTH && !pop_planned)
            ;
        else
            q.push_back({perr, d});
    endtask

    task automatic send(input logic [7:0] d, input int nb, input bit pe, input bit pb,
                        input int ns, input bit s1, input bit s2, input int de);
        rx_i = 1'b0;
        cyc(de);
        for (int i = 0; i < nb; i++) begin
            rx_i = d[i];
            cyc(de);
        end
        if (pe) begin
            rx_i = pb;
            cyc(de);
        end
        rx_i = s1;
        cyc(de);
        if (ns == 2) begin
            rx_i = s2;
            cyc(de);
        end
    endtask

    task automatic measure(output int n);
        n = -1;
        for (int i = 1; i <= 600; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk_i);
            if (newline_o) nl_cnt++;
            if (!rst_i && valid_o && ready_i) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected got=%h exp=none", {perr_o, data_o});
                end else begin
                    e = q.pop_front();
                    if ({perr_o, data_o} !== e) begin
                        errors++;
                        $display("FAIL pop_data got=%h exp=%h", {perr_o, data_o}, e);
                    end
                end
            end
        end
    endtask

    initial begin
        int         lat;
        int         nl0;
        logic [7:0] d;
        int         nb;
        int         dv;
        bit         pe;
        bit         od;
        bit         s2;
        bit         pb;

        rst_i     = 1'b1;
        rx_en_i   = 1'b1;
        rx_i      = 1'b1;
        ready_i   = 1'b1;
        err_clr_i = 1'b0;
        set_cfg(16, 8, 0, 0, 0);
        fork
            monitor();
        join_none
        cyc(3);
        chk("reset_outputs", {data_o, perr_o, valid_o, frame_err_o, overrun_o, newline_o, busy_o}, 0);
        rst_i = 1'b0;
        cyc(4);

        // 8N1 basic with exact latency
        expect_char(8'h55, 1'b0, 1'b0);
        fork
            send(8'h55, 8, 0, 0, 1, 1, 1, 16);
            measure(lat);
        join
        chk("lat_8n1", lat, 156);
        cyc(4);

        // Parity, 7 data bits
        set_cfg(8, 7, 1, 0, 0);
        expect_char(8'h41, exp_perr(8'h41, 7, 1, 0, 0), 1'b0);
        send(8'h41, 7, 1, 0, 1, 1, 1, 8);
        cyc(4);
        expect_char(8'h41, exp_perr(8'h41, 7, 1, 0, 1), 1'b0);
        send(8'h41, 7, 1, 1, 1, 1, 1, 8);
        cyc(4);
        set_cfg(8, 7, 1, 1, 0);
        expect_char(8'h41, exp_perr(8'h41, 7, 1, 1, 0), 1'b0);
        send(8'h41, 7, 1, 0, 1, 1, 1, 8);
        cyc(4);

        // Framing error on the second stop bit, followed by a break
        set_cfg(8, 8, 0, 0, 1);
        send(8'hA5, 8, 0, 0, 2, 1, 0, 8);
        cyc(30 * 8);
        chk("busy_in_break", busy_o, 1);
        chk("frame_err_set", frame_err_o, 1);
        chk("no_push_frame_err", valid_o, 0);
        rx_i = 1'b1;
        cyc(4);
        chk("busy_after_break", busy_o, 0);
        nl0 = nl_cnt;
        expect_char(8'h0A, 1'b0, 1'b0);
        send(8'h0A, 8, 0, 0, 2, 1, 1, 8);
        cyc(4);
        chk("newline_once", nl_cnt - nl0, 1);
        chk("frame_err_sticky", frame_err_o, 1);
        err_clr_i = 1'b1;
        cyc(1);
        err_clr_i = 1'b0;
        chk("frame_err_clr", frame_err_o, 0);

        // Overrun with ready low
        set_cfg(8, 8, 0, 0, 0);
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'h30 + 8'(i);
            expect_char(d, 1'b0, 1'b0);
            send(d, 8, 0, 0, 1, 1, 1, 8);
            cyc(2);
        end
        chk("overrun_set", overrun_o, 1);
        chk("full_valid", valid_o, 1);
        ready_i = 1'b1;
        cyc(10);
        chk("drained_valid", valid_o, 0);
        err_clr_i = 1'b1;
        cyc(1);
        err_clr_i = 1'b0;
        chk("overrun_clr", overrun_o, 0);

        // Push and pop on the same cycle while full
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = 8'h30 + 8'(i);
            expect_char(d, 1'b0, 1'b0);
            send(d, 8, 0, 0, 1, 1, 1, 8);
            cyc(2);
        end
        expect_char(8'h34, 1'b0, 1'b1);
        fork
            send(8'h34, 8, 0, 0, 1, 1, 1, 8);
            begin
                cyc(exp_lat(8, 8, 0, 1) - 1);
                ready_i = 1'b1;
                cyc(1);
                ready_i = 1'b0;
            end
        join
        cyc(2);
        chk("pushpop_full_no_overrun", overrun_o, 0);
        chk("pushpop_full_valid", valid_o, 1);
        ready_i = 1'b1;
        cyc(10);
        chk("pushpop_drained", valid_o, 0);

        // False start glitch of a quarter bit
        set_cfg(16, 8, 0, 0, 0);
        rx_i = 1'b0;
        cyc(4);
        rx_i = 1'b1;
        cyc(2);
        chk("glitch_busy", busy_o, 1);
        cyc(20);
        chk("glitch_idle", busy_o, 0);
        chk("glitch_no_push", valid_o, 0);

        // Reset in the middle of DATA
        ready_i = 1'b0;
        expect_char(8'h11, 1'b0, 1'b0);
        send(8'h11, 8, 0, 0, 1, 1, 1, 16);
        cyc(4);
        fork
            send(8'hFF, 8, 0, 0, 1, 1, 1, 16);
            begin
                cyc(40);
                chk("pre_reset_busy", busy_o, 1);
                chk("pre_reset_valid", valid_o, 1);
                rst_i = 1'b1;
                cyc(1);
                rst_i = 1'b0;
                q.delete();
                chk("mid_reset_outputs", {data_o, perr_o, valid_o, frame_err_o, overrun_o, newline_o, busy_o}, 0);
            end
        join
        ready_i = 1'b1;
        cyc(4);
        chk("post_reset_idle", busy_o, 0);
        expect_char(8'hC3, 1'b0, 1'b0);
        send(8'hC3, 8, 0, 0, 1, 1, 1, 16);
        cyc(4);

        // Divisor clamp
        set_cfg(2, 8, 0, 0, 0);
        expect_char(8'h7E, 1'b0, 1'b0);
        fork
            send(8'h7E, 8, 0, 0, 1, 1, 1, eff_div(2));
            measure(lat);
        join
        chk("lat_clamp", lat, exp_lat(eff_div(2), 8, 0, 1));
        cyc(4);

        // Receiver disabled, then disabled mid-frame
        set_cfg(8, 8, 0, 0, 0);
        rx_en_i = 1'b0;
        send(8'h99, 8, 0, 0, 1, 1, 1, 8);
        cyc(8);
        chk("disabled_no_push", valid_o, 0);
        chk("disabled_idle", busy_o, 0);
        rx_en_i = 1'b1;
        expect_char(8'h5A, 1'b0, 1'b0);
        fork
            send(8'h5A, 8, 0, 0, 1, 1, 1, 8);
            begin
                cyc(20);
                rx_en_i = 1'b0;
            end
        join
        cyc(4);
        rx_en_i = 1'b1;
        chk("en_drop_delivered", q.size(), 0);

        // Randomised frames against the model
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            nb = 5 + int'($urandom_range(0, 3));
            dv = int'($urandom_range(2, 12));
            pe = 1'($urandom_range(0, 1));
            od = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            pb = good_pbit(d, nb, od) ^ ($urandom_range(0, 3) == 0);
            set_cfg(dv, nb, pe, od, s2);
            expect_char(d & mask_of(nb), exp_perr(d, nb, pe, od, pb), 1'b0);
            send(d, nb, pe, pb, s2 ? 2 : 1, 1, 1, eff_div(dv));
            cyc(1 + int'($urandom_range(0, 5)));
        end
        cyc(20);
        chk("scoreboard_empty", q.size(), 0);
        chk("final_no_errors_flagged", {frame_err_o, overrun_o}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Clocked, synthesizable UART receiver for the uDMA UART testbench and RTL paths. It is the successor to the untimed console-print model.
- Runtime-configurable: bit divisor, character width 5–8, parity none/even/odd, 1 or 2 stop bits.
- Received characters go into a small FIFO behind a valid/ready stream, with per-character parity status and sticky framing/overrun flags.
- Sits between the serial pad (`rx`) and a consumer: a console logger, scoreboard or uDMA RX channel.

Parameters:
- FIFO_DEPTH, 4, number of character entries (power of 2, ≥2)
- DIV_W, 16, width of the clocks-per-bit divisor
- SYNC_STAGES, 2, input synchroniser flops on rx_i (≥2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; active-high, synchronous
- rx_en_i  in  1  receiver enable
- rx_i  in  1  serial line; idles high
- cfg_div_i  in  DIV_W  clocks per bit; values <4 are treated as 4
- cfg_bits_i  in  2  data bits minus 5 (0=5 … 3=8)
- cfg_parity_en_i  in  1  parity bit present
- cfg_parity_odd_i  in  1  1=odd parity, 0=even parity
- cfg_stop2_i  in  1  two stop bits
- data_o  out  8  FIFO head character, LSB-aligned, unused MSBs zero
- perr_o  out  1  FIFO head character had a parity error
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer pop; a pop occurs when valid_o & ready_i
- frame_err_o  out  1  sticky: a stop bit was sampled low
- overrun_o  out  1  sticky: a character was dropped because the FIFO was full
- err_clr_i  in  1  clears both sticky flags
- newline_o  out  1  one-cycle pulse when 8'h0A is pushed
- busy_o  out  1  state ≠ IDLE

Behaviour:
- **Reset** (rst_i=1 at a clk_i edge):
  - state IDLE, FIFO empty, counters 0, sync flops set to 1.
  - All outputs 0: data_o, perr_o, valid_o, frame_err_o, overrun_o, newline_o, busy_o.
- **Input sync:** rx_s is rx_i after SYNC_STAGES flops. All decisions use rx_s only.
- **Configuration capture:** all cfg_* inputs are latched when a start edge is detected and held for the whole frame. Mid-frame cfg changes have no effect.
- **States:** IDLE → START → DATA → [PARITY] → STOP → IDLE, plus WAIT_IDLE.
- **IDLE:**
  - When rx_en_i=1 and rx_s goes 1→0 (edge vs. previous cycle), go to START and load the counter with div/2.
  - When rx_en_i=0, stay in IDLE.
  - Deasserting rx_en_i mid-frame does not abort the frame.
- **START:** at counter expiry, sample rx_s.
  - 0: load the counter with div, go to DATA.
  - 1: false start, return to IDLE; nothing is pushed.
- **DATA:** sample one bit per div clocks, LSB first, for cfg_bits+5 bits, then go to PARITY if enabled, otherwise STOP.
- **PARITY:** sample p.
  - err = XOR(data bits) ^ p ^ odd.
  - err=1 is a parity error for both modes: even parity requires XOR of all bits = 0, odd requires 1.
- **STOP:** sample 1 or 2 stop bits, each div apart.
  - All samples 1: push {perr, data} into the FIFO on the cycle after the last stop sample, then go to IDLE.
  - Any sample 0: set frame_err_o, discard the character, go to WAIT_IDLE.
  - Under cfg_stop2, a 0 on the first stop sample aborts immediately.
- **WAIT_IDLE:** remain until rx_s=1 (break handling), then go to IDLE.
- **FIFO:**
  - valid_o rises the cycle after the push.
  - data_o and perr_o show the head entry; they are undefined-free: they read 0 when empty.
  - Push while full with no pop: drop the new character and set overrun_o.
  - Push and pop in the same cycle while full: both take effect; no overrun.
  - Push and pop in the same cycle while empty: no bypass; valid_o rises the next cycle.
- **Sticky flags:**
  - err_clr_i clears them.
  - If err_clr_i coincides with a new error event, the set wins.
- **newline_o:** pulses on the push cycle of 8'h0A, and only if the push is accepted.
- **Latency:** with div=D, valid_o rises SYNC_STAGES + 1 + D/2 + D·(N_bits + parity + stop) + 1 cycles after rx_i falls.

Decomposition:
- Package `uart_rx_pkg`:
  - `rx_state_e` enum
  - `rx_cfg_t` struct (div, bits, parity_en, parity_odd, stop2)
  - `rx_entry_t` {perr, data[7:0]}
  - `MIN_DIV`=4
- Sub-module `uart_rx_fifo`: parametrised synchronous FIFO of `rx_entry_t`, with full/empty, simultaneous push/pop, and drop-on-full reporting.

Test Plan:
1. **8N1 basic:** div=16, 8N1, send 8'h55 → data_o=8'h55, perr_o=0, valid_o rises exactly 2+1+8+144+1=156 cycles after rx_i falls.
2. **Parity:** div=8, 7 bits, even parity.
   - Send 8'h41 with correct parity 0 → perr_o=0.
   - Resend with parity bit 1 → perr_o=1, data_o=8'h41.
   - Switch to odd parity with the same bit 0 → perr_o=1.
3. **Framing:** 8N2, send 8'hA5 with the second stop bit driven 0, then hold rx low for 30 bit times → no push, frame_err_o=1, busy_o high until rx returns high.
   - Next frame 8'h0A is received correctly and newline_o pulses once.
   - err_clr_i clears frame_err_o.
4. **Overrun:** FIFO_DEPTH=4, ready_i=0, send 5 chars 8'h30–8'h34 → FIFO holds 8'h30–8'h33, overrun_o=1.
   - Then ready_i=1 pops the four in order, and valid_o falls.
   - Push+pop while full in the same cycle → no overrun.
5. **False start / reset mid-frame:**
   - A 0.25-bit low glitch on rx → no push, state back to IDLE.
   - rst_i asserted in DATA for 1 cycle → all outputs 0 next cycle, and the next full frame 8'hC3 is received correctly.
6. **Divisor clamp / enable:**
   - cfg_div_i=2 behaves as 4; verify timing for 8'h7E.
   - With rx_en_i=0, a frame is ignored.
   - Dropping rx_en_i mid-frame still delivers that character.
